// File: rtl/tile_hit_judge.sv
// Judges lane-button presses against the bottom-most tile and runs the IDLE/PLAY/OVER game FSM.
// Optional miss allowance (lives counter) enabled by defining TILE_JUDGE_LIVES_EN.
module tile_hit_judge #(
    parameter int unsigned LIVES_INIT = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       startn,
    input  logic [3:0] key_n,
    input  logic       tile_valid,
    input  logic [1:0] tile_lane,
    input  logic       tile_in_zone,
    input  logic       tile_passed,
    output logic       increment,
    output logic       tile_clear,
    output logic       miss,
    output logic       game_over,
    output logic [6:0] current_state,
    output logic [1:0] lives
);

    if (LIVES_INIT < 1 || LIVES_INIT > 3) begin : gen_lives_init_check
        $error("tile_hit_judge: LIVES_INIT must be in 1..3");
    end

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StOver = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic       start_s1_q, start_s2_q, start_prev_q;
    logic       start_press_q, start_rel_q;
    logic [3:0] key_s1_q, key_s2_q, key_prev_q;
    logic [3:0] key_press_q;

    // Synchronizers and edge detectors idle in the released (high) state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_s1_q    <= 1'b1;
            start_s2_q    <= 1'b1;
            start_prev_q  <= 1'b1;
            start_press_q <= 1'b0;
            start_rel_q   <= 1'b0;
            key_s1_q      <= 4'hF;
            key_s2_q      <= 4'hF;
            key_prev_q    <= 4'hF;
            key_press_q   <= 4'h0;
        end else begin
            start_s1_q    <= startn;
            start_s2_q    <= start_s1_q;
            start_prev_q  <= start_s2_q;
            start_press_q <= start_prev_q & ~start_s2_q;
            start_rel_q   <= ~start_prev_q & start_s2_q;
            key_s1_q      <= key_n;
            key_s2_q      <= key_s1_q;
            key_prev_q    <= key_s2_q;
            key_press_q   <= key_prev_q & ~key_s2_q;
        end
    end

    logic in_play;
    logic hit;
    logic miss_ev;
    logic last_life;

    // A hit needs exactly the tile's lane pressed; a coincident tile_passed folds into it.
    always_comb begin
        in_play = (state_q == StPlay);
        hit     = in_play && tile_valid && tile_in_zone &&
                  (key_press_q == (4'b0001 << tile_lane));
        miss_ev = in_play && !hit && ((|key_press_q) || tile_passed);
    end

`ifdef TILE_JUDGE_LIVES_EN
    localparam logic [1:0] LivesLoad = 2'(LIVES_INIT);

    logic [1:0] lives_q, lives_d;

    assign last_life = (lives_q <= 2'd1);

    always_comb begin
        lives_d = lives_q;
        if (state_q == StIdle && state_d == StPlay) begin
            lives_d = LivesLoad;
        end else if (miss_ev && lives_q != 2'd0) begin
            lives_d = lives_q - 2'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lives_q <= LivesLoad;
        end else begin
            lives_q <= lives_d;
        end
    end

    assign lives = lives_q;
`else
    assign last_life = 1'b1;
    assign lives     = 2'd0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_rel_q) state_d = StPlay;
            StPlay:  if (miss_ev && last_life) state_d = StOver;
            StOver:  if (start_press_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    logic inc_q, clr_q, miss_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            inc_q   <= 1'b0;
            clr_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inc_q   <= hit;
            clr_q   <= hit;
            miss_q  <= miss_ev;
        end
    end

    assign increment     = inc_q;
    assign tile_clear    = clr_q;
    assign miss          = miss_q;
    assign game_over     = (state_q == StOver);
    assign current_state = {5'b00000, state_q};

endmodule

// File: tb/tb_tile_hit_judge.sv
// Scoreboard bench for tile_hit_judge: transactions push expected pulses, a monitor pops them.
// Adapts to builds with or without TILE_JUDGE_LIVES_EN.
module tb_tile_hit_judge;

    localparam int unsigned LIVES_INIT = 3;
`ifdef TILE_JUDGE_LIVES_EN
    localparam bit LIVES_EN = 1'b1;
`else
    localparam bit LIVES_EN = 1'b0;
`endif
    // Negedges from driving a key low until the negedge before the judging clock edge.
    localparam int LAT = 3;

    logic       clock;
    logic       reset;
    logic       startn;
    logic [3:0] key_n;
    logic       tile_valid;
    logic [1:0] tile_lane;
    logic       tile_in_zone;
    logic       tile_passed;
    logic       increment;
    logic       tile_clear;
    logic       miss;
    logic       game_over;
    logic [6:0] current_state;
    logic [1:0] lives;

    tile_hit_judge #(
        .LIVES_INIT(LIVES_INIT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .startn       (startn),
        .key_n        (key_n),
        .tile_valid   (tile_valid),
        .tile_lane    (tile_lane),
        .tile_in_zone (tile_in_zone),
        .tile_passed  (tile_passed),
        .increment    (increment),
        .tile_clear   (tile_clear),
        .miss         (miss),
        .game_over    (game_over),
        .current_state(current_state),
        .lives        (lives)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        bit is_hit;
        int lives;
        int state;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   m_state;  // 0 idle, 1 play, 2 over
    int   m_lives;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (increment || miss || tile_clear) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: inc=%0b clr=%0b miss=%0b expected no pulse",
                             increment, tile_clear, miss);
                end else begin
                    e = q.pop_front();
                    check("pulse_increment", int'(increment), int'(e.is_hit));
                    check("pulse_tile_clear", int'(tile_clear), int'(e.is_hit));
                    check("pulse_miss", int'(miss), int'(!e.is_hit));
                    check("pulse_lives", int'(lives), e.lives);
                    check("pulse_state", int'(current_state), e.state);
                    check("pulse_game_over", int'(game_over), int'(e.state == 2));
                end
            end
        end
    end

    // Reference model of one judged cycle.
    task automatic model_judge(input logic [3:0] mask, input bit v, input logic [1:0] lane,
                               input bit zone, input bit passed);
        exp_t e;
        bit   is_hit;
        if (m_state != 1) return;
        is_hit = ($countones(mask) == 1) && v && zone && mask[lane];
        if (is_hit) begin
            e.is_hit = 1'b1;
            e.lives  = m_lives;
            e.state  = 1;
            q.push_back(e);
        end else if (mask != 4'h0 || passed) begin
            if (LIVES_EN) begin
                m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                if (m_lives == 0) m_state = 2;
            end else begin
                m_state = 2;
            end
            e.is_hit = 1'b0;
            e.lives  = m_lives;
            e.state  = m_state;
            q.push_back(e);
        end
    endtask

    task automatic settle_check(input string name);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_pulse: outstanding=%0d expected 0", name, q.size());
            q.delete();
        end
        check({name, "_state"}, int'(current_state), m_state);
        check({name, "_lives"}, int'(lives), m_lives);
        check({name, "_game_over"}, int'(game_over), int'(m_state == 2));
    endtask

    task automatic do_start(input int low_cycles);
        bit from_idle;
        bit from_play;
        from_idle = (m_state == 0);
        from_play = (m_state == 1);
        @(negedge clock);
        startn = 1'b0;
        for (int i = 0; i < low_cycles; i++) begin
            @(negedge clock);
            if (!from_play && (from_idle || i >= 3))
                check("idle_while_startn_low", int'(current_state), 0);
        end
        startn = 1'b1;
        if (!from_play) begin
            repeat (3) @(negedge clock);
            check("start_latency_pre", int'(current_state), 0);
            @(negedge clock);
            check("start_latency", int'(current_state), 1);
            m_state = 1;
            if (LIVES_EN) m_lives = LIVES_INIT;
        end else begin
            repeat (4) @(negedge clock);
        end
        repeat (2) @(negedge clock);
        settle_check("start");
    endtask

    task automatic ensure_play();
        if (m_state != 1) do_start(4);
    endtask

    task automatic do_press(input logic [3:0] mask, input bit v, input logic [1:0] lane,
                            input bit zone, input bit passed);
        @(negedge clock);
        tile_valid   = v;
        tile_lane    = lane;
        tile_in_zone = zone;
        key_n        = ~mask;
        model_judge(mask, v, lane, zone, passed);
        repeat (LAT) @(negedge clock);
        if (passed) tile_passed = 1'b1;
        @(negedge clock);
        tile_passed = 1'b0;
        key_n       = 4'hF;
        repeat (5) @(negedge clock);
        settle_check("press");
    endtask

    task automatic do_passed();
        @(negedge clock);
        tile_passed = 1'b1;
        model_judge(4'h0, tile_valid, tile_lane, tile_in_zone, 1'b1);
        @(negedge clock);
        tile_passed = 1'b0;
        repeat (4) @(negedge clock);
        settle_check("passed");
    endtask

    // A hit is in flight when reset lands; nothing may come out afterwards.
    task automatic do_mid_reset();
        @(negedge clock);
        tile_valid   = 1'b1;
        tile_lane    = 2'd2;
        tile_in_zone = 1'b1;
        key_n        = 4'b1011;
        repeat (LAT) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check("mid_reset_state", int'(current_state), 0);
        check("mid_reset_game_over", int'(game_over), 0);
        m_state = 0;
        m_lives = LIVES_EN ? LIVES_INIT : 0;
        check("mid_reset_lives", int'(lives), m_lives);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        key_n = 4'hF;
        repeat (5) @(negedge clock);
        settle_check("mid_reset");
    endtask

    initial begin : stim
        logic [3:0] mask;
        logic [1:0] lane;
        int         r;
        reset        = 1'b1;
        startn       = 1'b1;
        key_n        = 4'hF;
        tile_valid   = 1'b0;
        tile_lane    = 2'd0;
        tile_in_zone = 1'b0;
        tile_passed  = 1'b0;
        m_state      = 0;
        m_lives      = LIVES_EN ? LIVES_INIT : 0;
        repeat (3) @(negedge clock);
        check("reset_state", int'(current_state), 0);
        check("reset_increment", int'(increment), 0);
        check("reset_tile_clear", int'(tile_clear), 0);
        check("reset_miss", int'(miss), 0);
        check("reset_game_over", int'(game_over), 0);
        check("reset_lives", int'(lives), m_lives);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        do_start(5);
        do_press(4'b0100, 1'b1, 2'd2, 1'b1, 1'b0);   // correct hit
        do_press(4'b1000, 1'b1, 2'd1, 1'b1, 1'b0);   // wrong lane
        ensure_play();
        do_press(4'b0011, 1'b1, 2'd0, 1'b1, 1'b0);   // two lanes at once
        ensure_play();
        do_press(4'b0001, 1'b1, 2'd0, 1'b1, 1'b1);   // hit wins over tile_passed
        ensure_play();
        do_press(4'b0010, 1'b1, 2'd0, 1'b1, 1'b1);   // miss-press plus passed: one miss
        ensure_play();
        do_press(4'b0001, 1'b1, 2'd0, 1'b0, 1'b0);   // outside zone

        do_mid_reset();
        do_start(6);
        do_passed();
        do_passed();
        do_passed();
        do_press(4'b0100, 1'b1, 2'd2, 1'b1, 1'b0);   // ignored once over
        do_start(5);

        for (int it = 0; it < 200; it++) begin
            r = int'($urandom_range(0, 9));
            if (m_state != 1) begin
                if (r < 4) do_press(4'(1 << $urandom_range(0, 3)), 1'b1, 2'($urandom_range(0, 3)),
                                    1'b1, 1'b0);
                do_start(int'($urandom_range(4, 7)));
            end else if (r < 2) begin
                do_passed();
            end else if (r == 2) begin
                do_start(int'($urandom_range(4, 7)));
            end else begin
                lane = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 9) < 6) mask = 4'(1 << lane);
                else mask = 4'($urandom_range(1, 15));
                do_press(mask, $urandom_range(0, 9) < 8, lane, $urandom_range(0, 9) < 8,
                         $urandom_range(0, 4) == 0);
            end
        end

        repeat (4) @(negedge clock);
        settle_check("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_hit_judge.md
TILE_HIT_JUDGE -- requirements
Module: tile_hit_judge

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-high.
REQ-002 Parameter LIVES_INIT, default 3, SHALL set the miss allowance loaded into the lives counter; legal range 1..3.
REQ-003 clock  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 startn  input  1  start button, active-low, asynchronous to clock.
REQ-006 key_n  input  4  lane buttons, active-low, asynchronous; bit i is lane i.
REQ-007 tile_valid  input  1  a bottom-most tile exists.
REQ-008 tile_lane  input  2  lane of the bottom-most tile.
REQ-009 tile_in_zone  input  1  the bottom-most tile is inside the hit zone.
REQ-010 tile_passed  input  1  one-cycle pulse: the bottom-most tile left the zone without being hit.
REQ-011 increment  output  1  one-cycle pulse per correct hit; drives the score counter.
REQ-012 tile_clear  output  1  one-cycle pulse requesting removal of the hit tile.
REQ-013 miss  output  1  one-cycle pulse per judged miss.
REQ-014 game_over  output  1  level, high while in OVER.
REQ-015 current_state  output  7  state encoding: IDLE=0, PLAY=1, OVER=2; upper bits are 0.
REQ-016 lives  output  2  remaining lives.

Function
REQ-017 startn and each key_n bit SHALL pass through a 2-flop synchronizer, then a registered edge detector.
- Press = synchronized 1->0 transition.
- Release = synchronized 0->1 transition.
REQ-018 FSM transitions SHALL be:
- IDLE->PLAY on startn release.
- PLAY->OVER on the miss that exhausts lives.
- OVER->IDLE on startn press.
- All other cases hold state.
REQ-019 While startn is held low, the FSM SHALL remain in IDLE.
REQ-020 Judgements SHALL occur only in PLAY; key presses in IDLE or OVER SHALL be ignored.
REQ-021 Hit: exactly one lane pressed this cycle, with tile_valid=1, tile_in_zone=1 and tile_lane equal to the pressed lane.
REQ-022 On a hit, increment and tile_clear SHALL be asserted together for exactly one cycle, on the cycle after the press is detected.
REQ-023 Miss: any press that is not a hit, including two or more lanes pressed in the same cycle.
REQ-024 Any tile_passed pulse in PLAY SHALL also count as a miss.
REQ-025 On a miss, miss SHALL be asserted for one cycle, with the same latency as a hit.
REQ-026 If a hit and tile_passed occur in the same cycle, the hit SHALL win: no miss is generated.
REQ-027 If a miss-press and tile_passed occur in the same cycle, only one miss SHALL be generated.
REQ-028 At most one of hit or miss SHALL be produced per cycle.
REQ-029 The lives counter SHALL saturate at 0 and never wrap.
REQ-030 game_over SHALL rise in the same cycle current_state becomes 2.
REQ-031 A miss that exhausts lives SHALL produce the miss pulse and the PLAY->OVER transition together.

Reset
REQ-032 Asserting reset SHALL immediately set:
- current_state=0
- increment=0, tile_clear=0, miss=0, game_over=0
- lives=LIVES_INIT (or 0 without the macro)
- all synchronizer and edge flops to 1 (released)
REQ-033 Reset asserted mid-game SHALL discard any pending pulse; no output pulse may appear in the cycle after reset deasserts.

Configuration
REQ-034 Macro TILE_JUDGE_LIVES_EN defined: the lives counter loads LIVES_INIT on entry to PLAY and decrements by 1 per miss; the game ends when lives reaches 0.
REQ-035 Macro TILE_JUDGE_LIVES_EN undefined: no lives counter; the first miss causes PLAY->OVER and lives is tied to 0.

Verification
REQ-036 The bench SHALL cover at least these scenarios:
- Reset, pulse startn low 5 cycles then high -> current_state 0 during the low period, 1 four cycles after the release (2 sync + 1 edge + 1 state register).
- PLAY, tile_valid=1, tile_in_zone=1, tile_lane=2, press key_n[2] -> one-cycle increment and tile_clear; miss=0; lives unchanged.
- PLAY, tile_lane=1, press key_n[3] -> one-cycle miss; lives 3->2 (LIVES_EN, LIVES_INIT=3).
- PLAY, key_n[0] and key_n[1] pressed in the same cycle with a valid tile in lane 0 -> one miss; no increment.
- Correct-lane hit coincident with a tile_passed pulse -> increment only; miss=0.
- LIVES_EN, three tile_passed pulses -> lives 2,1,0; current_state=2 and game_over=1 on the third miss; a later key press produces no pulse; startn press -> state 0.
